// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher.
// Holds the FSM state encoding and a width helper used for parameter defaults.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Number of bits needed to hold the value v (always at least 1).
  function automatic int width_for(input longint v);
    int w;
    w = 1;
    while ((longint'(1) << w) <= v) w++;
    return w;
  endfunction

endpackage

// File: rtl/pulse_stretch_sat_cnt.sv
// sat_updown_cnt: saturating up/down counter with synchronous clear.
// Counting up stops at MAX, counting down stops at 0, and a simultaneous
// inc+dec leaves the value untouched (including at saturation).
module sat_updown_cnt #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CMAX = W'(MAX);

  // Counter register: clear wins, then net up or net down with clamping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CMAX) cnt <= cnt + W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle events into ON_CYCLES-long output pulses
// separated by at least GAP_CYCLES low cycles. Events arriving while busy are
// queued (up to MAX_PEND) and replayed in order.
// Optional build macro PULSE_STRETCH_OVF_EN adds a sticky 'ovf' output that
// flags events dropped because the pending queue was full.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int MAX_PEND   = 7,
  parameter int CNT_W      = width_for(((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) - 1),
  parameter int PEND_W     = width_for(MAX_PEND)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt
`ifdef PULSE_STRETCH_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] dur_cnt;
  logic             has_pend;
  logic             start;
  logic             gap_done;
  logic             go_on;
  logic             pend_inc;
  logic             pend_dec;

  assign has_pend = (pend_cnt != '0);
  assign start    = pulse_in || has_pend;
  assign gap_done = (state == ST_GAP) && (dur_cnt == GAP_LAST);
  // A new output pulse begins on the next edge: from IDLE, or straight out of
  // the last GAP cycle without passing through IDLE.
  assign go_on    = !clear && start && ((state == ST_IDLE) || gap_done);
  // A queued event is consumed whenever a pulse starts while the queue is
  // non-empty; the incoming pulse (if any) then joins the queue instead.
  assign pend_dec = go_on && has_pend;
  assign pend_inc = pulse_in && !clear && !(go_on && !has_pend);

  sat_updown_cnt #(
    .MAX (MAX_PEND),
    .W   (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .cnt   (pend_cnt)
  );

  // Main FSM with duration counter and registered level output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dur_cnt   <= '0;
      level_out <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      dur_cnt   <= '0;
      level_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_on) begin
            state     <= ST_ON;
            dur_cnt   <= '0;
            level_out <= 1'b1;
          end
        end
        ST_ON: begin
          if (dur_cnt == ON_LAST) begin
            state     <= ST_GAP;
            dur_cnt   <= '0;
            level_out <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            dur_cnt <= '0;
            if (go_on) begin
              state     <= ST_ON;
              level_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            dur_cnt <= dur_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          dur_cnt   <= '0;
          level_out <= 1'b0;
        end
      endcase
    end
  end

  // Busy is a pure decode of registered state.
  assign busy = (state != ST_IDLE) || has_pend;

`ifdef PULSE_STRETCH_OVF_EN
  logic drop;
  // An event is lost when it would be queued but the queue is full and
  // nothing is leaving it on the same edge.
  assign drop = pend_inc && !pend_dec && (pend_cnt == PEND_W'(MAX_PEND));

  // Sticky overflow flag, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= 1'b0;
    else if (clear)  ovf <= 1'b0;
    else if (drop)   ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch (ON=4, GAP=2, MAX_PEND=3).
// The reference model schedules each accepted event as an interval
// [start, start+ON) of high output followed by GAP low cycles, derived from
// arrival times; pending count is the number of events that arrived but have
// not started yet.
module tb_pulse_stretch;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int MAXP = 3;
  localparam int CW   = 2;
  localparam int PW   = 2;
  localparam int NEV  = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse_in;
  logic          clear;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pend_cnt;
`ifdef PULSE_STRETCH_OVF_EN
  logic          ovf;
`endif

  pulse_stretch #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .MAX_PEND   (MAXP),
    .CNT_W      (CW),
    .PEND_W     (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .clear     (clear),
    .level_out (level_out),
    .busy      (busy),
    .pend_cnt  (pend_cnt)
`ifdef PULSE_STRETCH_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: event schedule.
  int ev_arr      [NEV];
  int ev_start    [NEV];
  int ev_on_end   [NEV];
  int ev_busy_end [NEV];
  bit ev_ok       [NEV];
  int n_ev;
  int free_at;
  bit ovf_m;
  logic [PW+2:0] exp_vec;

  function automatic void model_reset();
    n_ev    = 0;
    free_at = 0;
    ovf_m   = 1'b0;
  endfunction

  function automatic int pend_at(int t);
    int c = 0;
    for (int i = 0; i < n_ev; i++)
      if (ev_ok[i] && ev_arr[i] < t && ev_start[i] > t) c++;
    return c;
  endfunction

  function automatic logic [PW+2:0] model_vec(int t);
    bit lvl = 1'b0;
    bit bsy = 1'b0;
    int pd  = pend_at(t);
    for (int i = 0; i < n_ev; i++) begin
      if (ev_ok[i] && ev_start[i] <= t && t < ev_on_end[i])   lvl = 1'b1;
      if (ev_ok[i] && ev_start[i] <= t && t < ev_busy_end[i]) bsy = 1'b1;
    end
    if (pd != 0) bsy = 1'b1;
`ifdef PULSE_STRETCH_OVF_EN
    return {lvl, bsy, PW'(pd), ovf_m};
`else
    return {lvl, bsy, PW'(pd), 1'b0};
`endif
  endfunction

  function automatic logic [PW+2:0] obs_vec();
`ifdef PULSE_STRETCH_OVF_EN
    return {level_out, busy, pend_cnt, ovf};
`else
    return {level_out, busy, pend_cnt, 1'b0};
`endif
  endfunction

  // Drive one cycle's inputs, advance the model, and move to mid-cycle.
  task automatic step(input bit p, input bit c);
    int s, pd;
    bit d;
    exp_vec = model_vec(cyc);
    if (c) begin
      for (int i = 0; i < n_ev; i++) begin
        if (ev_ok[i]) begin
          if (ev_start[i] > cyc) ev_ok[i] = 1'b0;
          else begin
            if (ev_on_end[i] > cyc + 1)   ev_on_end[i]   = cyc + 1;
            if (ev_busy_end[i] > cyc + 1) ev_busy_end[i] = cyc + 1;
          end
        end
      end
      free_at = cyc + 1;
      ovf_m   = 1'b0;
    end else if (p) begin
      s  = (free_at > cyc + 1) ? free_at : cyc + 1;
      pd = pend_at(cyc);
      d  = 1'b0;
      for (int i = 0; i < n_ev; i++)
        if (ev_ok[i] && ev_arr[i] < cyc && ev_start[i] == cyc + 1) d = 1'b1;
      if ((pd == 0 && s == cyc + 1) || (pd - int'(d) + 1 <= MAXP)) begin
        ev_arr[n_ev]      = cyc;
        ev_start[n_ev]    = s;
        ev_on_end[n_ev]   = s + ON;
        ev_busy_end[n_ev] = s + ON + GAP;
        ev_ok[n_ev]       = 1'b1;
        n_ev++;
        free_at = s + ON + GAP;
      end else begin
        ovf_m = 1'b1;
      end
    end
    pulse_in = p;
    clear    = c;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    pulse_in = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 10;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_in = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_async got %b exp %b", obs_vec(), {(PW+3){1'b0}});
    end
    n_tests++;
    @(posedge clk); #1;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_held got %b exp %b", obs_vec(), {(PW+3){1'b0}});
    end
    n_tests++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    model_reset();
  endtask

  task automatic test_single();
    for (int k = 0; k < 16; k++) begin
      step(k == 2, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL single cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      tick();
    end
  endtask

  task automatic test_burst();
    int rises = 0;
    bit prev  = 1'b0;
    for (int k = 0; k < 26; k++) begin
      step(k >= 2 && k <= 4, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL burst cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      if (level_out && !prev) rises++;
      prev = level_out;
      tick();
    end
    if (rises != 3) begin
      n_fail++; $display("FAIL burst_pulses got %0d exp 3", rises);
    end
    n_tests++;
  endtask

  task automatic test_saturation();
    int rises = 0;
    bit prev  = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step(k >= 2 && k <= 7, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL saturation cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      if (level_out && !prev) rises++;
      prev = level_out;
      tick();
    end
    if (rises != 4) begin
      n_fail++; $display("FAIL saturation_pulses got %0d exp 4", rises);
    end
    n_tests++;
    // Sticky flag must not leak into the next scenario.
    step(1'b0, 1'b1);
    tick();
  endtask

  task automatic test_clear();
    for (int k = 0; k < 16; k++) begin
      step(k == 0 || k == 1 || k == 3, k == 3);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL clear cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 8; k++) begin
      step(k == 2, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL async_pre cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      if (k < 7) tick();
    end
    // Now mid-cycle in GAP: assert reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL async_rst got %b exp %b", obs_vec(), {(PW+3){1'b0}});
    end
    n_tests++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 10;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      step(k == 2, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL async_post cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      tick();
    end
  endtask

  task automatic test_gap_terminal();
    // First pulse starts at +3, GAP occupies +7..+8; second pulse lands on +8.
    for (int k = 0; k < 18; k++) begin
      step(k == 2 || k == 8, 1'b0);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL gap_term cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      if (k == 9 && level_out !== 1'b1) begin
        n_fail++; $display("FAIL gap_term_rise got %b exp 1", level_out);
      end
      if (k == 9) n_tests++;
      tick();
    end
  endtask

  task automatic test_random();
    bit p, c;
    apply_reset();
    for (int k = 0; k < 440; k++) begin
      p = (k < 400) && ($urandom_range(0, 2) == 0);
      c = (k < 400) && ($urandom_range(0, 39) == 0);
      step(p, c);
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL random cyc=%0d got %b exp %b", cyc, obs_vec(), exp_vec);
      end
      n_tests++;
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_clear();
    test_async_reset();
    test_gap_terminal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
